// File: rtl/sixteen_bit_ld_register.sv
// sixteen_bit_ld_register
// Parallel-load storage register with an active-high load enable.
// When ld is high, in is captured on the rising clock edge. Otherwise the
// stored value is held. The asynchronous active-low reset forces RESET_VALUE
// immediately and takes priority over ld. out is driven straight from the
// flops, so there is no combinational path from in or ld to out.

module sixteen_bit_ld_register #(
   parameter int                 WIDTH       = 16,
   parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] out_q;

   // Next-state selection: capture in on a load, otherwise recirculate the held value
   always_comb begin
      out_d = out_q;
      if (ld == 1'b1) begin
         out_d = in;
      end else begin
         out_d = out_q;
      end
   end

   // Storage flops: asynchronous clear to RESET_VALUE, otherwise take the selected next value
   always_ff @(posedge clk or negedge rst) begin
      if (rst == 1'b0) begin
         out_q <= RESET_VALUE;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_sixteen_bit_ld_register.sv
// tb_sixteen_bit_ld_register
// The bench uses directed sequences, then a vector table, then randomized
// cycles compared against a behavioural model of the load register.

module tb_sixteen_bit_ld_register;

   logic        clk;
   logic        rst;
   logic        ld;
   logic [15:0] in;
   logic [15:0] out;

   int n_total;
   int n_pass;

   sixteen_bit_ld_register #(
      .WIDTH       (16),
      .RESET_VALUE (16'h0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ld  (ld),
      .in  (in),
      .out (out)
   );

   // 10-time-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Absolute time limit so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got %0d/%0d", n_pass, n_total);
      $fatal(1);
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: out=%h expected=%h at t=%0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Advance past the next rising edge and settle before sampling
   task automatic edge_and_settle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rst;
      logic        ld;
      logic [15:0] din;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[8];

   // Behavioural reference: the value the register should hold
   logic [15:0] model_val;

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst = 1'b1;
      ld  = 1'b0;
      in  = 16'h0000;

      vecs[0] = '{1'b1, 1'b1, 16'hBEEF, 16'hBEEF};
      vecs[1] = '{1'b1, 1'b0, 16'h0000, 16'hBEEF};
      vecs[2] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF};
      vecs[3] = '{1'b1, 1'b1, 16'h0000, 16'h0000};
      vecs[4] = '{1'b0, 1'b1, 16'h1234, 16'h0000};
      vecs[5] = '{1'b1, 1'b0, 16'h4321, 16'h0000};
      vecs[6] = '{1'b1, 1'b1, 16'h7FFF, 16'h7FFF};
      vecs[7] = '{1'b1, 1'b0, 16'h8001, 16'h7FFF};

      // 1. Reset overrides load, effective immediately and across edges
      #2;
      in  = 16'h1234;
      ld  = 1'b1;
      rst = 1'b0;
      #1;
      check("reset_immediate", out, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         edge_and_settle();
         check("reset_held_over_edge", out, 16'h0000);
      end

      // 2. Hold with ld low after reset release
      @(negedge clk);
      rst = 1'b1;
      ld  = 1'b0;
      in  = 16'hFFFF;
      for (int i = 0; i < 2; i++) begin
         edge_and_settle();
         check("hold_after_reset", out, 16'h0000);
      end

      // 3. Load: unchanged before the edge, new value after it
      @(negedge clk);
      ld = 1'b1;
      in = 16'hAAAA;
      #1;
      check("load_before_edge", out, 16'h0000);
      edge_and_settle();
      check("load_AAAA", out, 16'hAAAA);

      // 4. Retain, then load 5555
      @(negedge clk);
      ld = 1'b0;
      in = 16'h5555;
      edge_and_settle();
      check("retain_AAAA", out, 16'hAAAA);
      @(negedge clk);
      ld = 1'b1;
      edge_and_settle();
      check("load_5555", out, 16'h5555);

      // 5. Back-to-back loads
      @(negedge clk);
      in = 16'h0001;
      edge_and_settle();
      check("b2b_0001", out, 16'h0001);
      @(negedge clk);
      in = 16'h8000;
      edge_and_settle();
      check("b2b_8000", out, 16'h8000);

      // 6. Async reset pulse between edges
      @(negedge clk);
      in = 16'h5555;
      edge_and_settle();
      check("preload_5555", out, 16'h5555);
      @(negedge clk);
      ld = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      check("async_mid_cycle", out, 16'h0000);
      rst = 1'b1;
      edge_and_settle();
      check("after_release_hold", out, 16'h0000);

      // Vector table
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rst = vecs[i].rst;
         ld  = vecs[i].ld;
         in  = vecs[i].din;
         edge_and_settle();
         check($sformatf("vec%0d", i), out, vecs[i].exp);
      end

      // Randomized cycles against the behavioural model
      @(negedge clk);
      rst = 1'b1;
      model_val = 16'h7FFF;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         ld  = 1'($urandom_range(0, 1));
         in  = 16'($urandom);
         rst = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
         if (rst == 1'b1 && $urandom_range(0, 7) == 0) begin
            #1;
            rst = 1'b0;
            #1;
            model_val = 16'h0000;
            check("rand_async_pulse", out, model_val);
            rst = 1'b1;
         end
         edge_and_settle();
         if (rst == 1'b0) begin
            model_val = 16'h0000;
         end else if (ld == 1'b1) begin
            model_val = in;
         end else begin
            model_val = model_val;
         end
         check("rand_cycle", out, model_val);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
